// File: rtl/pipe_pkg.sv
// Shared types for the PIPE rate / PowerDown change controller.
package pipe_pkg;

    typedef enum logic [3:0] {
        P0  = 4'd0,
        P0s = 4'd1,
        P1  = 4'd2,
        P2  = 4'd3
    } pd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OK  = 2'd1,
        WAIT_PHY = 2'd2,
        DONE     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        TIMEOUT = 2'd1,
        NOMASK  = 2'd2
    } status_e;

    localparam pd_e PD_RESET = P1;

endpackage

// File: rtl/pipe_rate_pd_ctrl_if.sv
// LTSSM request/done handshake plus the PIPE Rate/PowerDown/PCLK signal bundle.
interface pipe_rate_pd_ctrl_if #(
    parameter int LANESNUMBER = 16
);
    logic                     req_valid;
    logic                     req_ready;
    logic [3:0]               req_rate;
    logic [3:0]               req_powerdown;
    logic                     req_pclk_change;
    logic [4:0]               req_pclkrate;
    logic [LANESNUMBER-1:0]   req_lane_mask;
    logic                     done;
    logic [1:0]               done_status;
    logic                     busy;
    logic [3:0]               Rate;
    logic [4*LANESNUMBER-1:0] PowerDown;
    logic [4:0]               PCLKRate;
    logic                     PclkChangeAck;
    logic                     PclkChangeOk;
    logic [LANESNUMBER-1:0]   PhyStatus;

    // Environment side: LTSSM issuing requests and PHY returning status.
    modport master (
        output req_valid, req_rate, req_powerdown, req_pclk_change, req_pclkrate,
               req_lane_mask, PclkChangeOk, PhyStatus,
        input  req_ready, done, done_status, busy, Rate, PowerDown, PCLKRate,
               PclkChangeAck
    );

    // Controller side.
    modport slave (
        input  req_valid, req_rate, req_powerdown, req_pclk_change, req_pclkrate,
               req_lane_mask, PclkChangeOk, PhyStatus,
        output req_ready, done, done_status, busy, Rate, PowerDown, PCLKRate,
               PclkChangeAck
    );

endinterface

// File: rtl/pipe_lane_status_collector.sv
// Sticky per-lane PhyStatus collector; reports when every masked lane has answered.
module pipe_lane_status_collector #(
    parameter int LANESNUMBER = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic [LANESNUMBER-1:0] mask,
    input  logic [LANESNUMBER-1:0] phy_status,
    output logic                   all_done
);

    logic [LANESNUMBER-1:0] sticky;

    // Remember which masked lanes have pulsed since the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else if (clr) begin
            sticky <= '0;
        end else if (en) begin
            sticky <= sticky | (phy_status & mask);
        end
    end

    // Include the live pulses so the completing lane counts in its own cycle.
    always_comb begin
        all_done = (((sticky | phy_status) & mask) == mask);
    end

endmodule

// File: rtl/pipe_rate_pd_ctrl.sv
// MAC-side sequencer for PIPE Rate / PowerDown / PCLKRate changes with PHY handshake.
module pipe_rate_pd_ctrl
    import pipe_pkg::*;
#(
    parameter int LANESNUMBER    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                CLK,
    input logic                RST_n,
    pipe_rate_pd_ctrl_if.slave bus
);

    localparam int CNTW = $clog2(TIMEOUT_CYCLES);

    state_e                 state;
    state_e                 next_state;
    status_e                next_status;
    logic [LANESNUMBER-1:0] mask;
    logic [CNTW-1:0]        count;
    logic                   accept;
    logic                   waiting;
    logic                   at_limit;
    logic                   collect;
    logic                   all_done;

    pipe_lane_status_collector #(
        .LANESNUMBER(LANESNUMBER)
    ) u_collector (
        .clk       (CLK),
        .rst_n     (RST_n),
        .clr       (accept),
        .en        (collect),
        .mask      (mask),
        .phy_status(bus.PhyStatus),
        .all_done  (all_done)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and the status to report on entry to DONE; completion beats timeout.
    always_comb begin
        next_state  = state;
        next_status = status_e'(bus.done_status);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_lane_mask == '0) begin
                        next_state  = DONE;
                        next_status = NOMASK;
                    end else if (bus.req_pclk_change) begin
                        next_state = WAIT_OK;
                    end else begin
                        next_state = WAIT_PHY;
                    end
                end
            end
            WAIT_OK: begin
                if (at_limit) begin
                    next_state  = DONE;
                    next_status = TIMEOUT;
                end else if (bus.PclkChangeOk) begin
                    next_state = WAIT_PHY;
                end
            end
            WAIT_PHY: begin
                if (all_done) begin
                    next_state  = DONE;
                    next_status = OK;
                end else if (at_limit) begin
                    next_state  = DONE;
                    next_status = TIMEOUT;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State-decoded handshake and timer qualifiers.
    always_comb begin
        bus.req_ready = (state == IDLE);
        accept        = bus.req_valid && (state == IDLE);
        waiting       = (state == WAIT_OK) || (state == WAIT_PHY);
        collect       = (state == WAIT_PHY);
        at_limit      = waiting && (count == CNTW'(TIMEOUT_CYCLES - 1));
    end

    // Registered outputs, latched mask and timeout counter.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.done_status   <= 2'b00;
            bus.Rate          <= 4'd0;
            bus.PowerDown     <= {LANESNUMBER{4'(PD_RESET)}};
            bus.PCLKRate      <= 5'd0;
            bus.PclkChangeAck <= 1'b0;
            mask              <= '0;
            count             <= '0;
        end else begin
            bus.busy        <= (next_state != IDLE);
            bus.done        <= (next_state == DONE);
            bus.done_status <= next_status;

            if (accept) begin
                count <= '0;
            end else if (waiting) begin
                count <= count + CNTW'(1);
            end

            if (accept) begin
                mask <= bus.req_lane_mask;
                if (bus.req_lane_mask != '0) begin
                    bus.Rate <= bus.req_rate;
                    for (int i = 0; i < LANESNUMBER; i++) begin
                        if (bus.req_lane_mask[i]) begin
                            bus.PowerDown[4*i +: 4] <= bus.req_powerdown;
                        end
                    end
                    if (bus.req_pclk_change) begin
                        bus.PCLKRate <= bus.req_pclkrate;
                    end
                end
            end

            if (state == WAIT_OK && next_state == WAIT_PHY) begin
                bus.PclkChangeAck <= 1'b1;
            end else if (next_state == DONE) begin
                bus.PclkChangeAck <= 1'b0;
            end
        end
    end

endmodule
